// File: rtl/spi_to_ahb_bridge_if.sv
// AHB-Lite bus bundle between the SPI bridge (bus master) and an AHB slave.
//   master : drives HADDR/HTRANS/HWRITE/HSIZE/HBURST/HWDATA, receives HRDATA/HREADY/HRESP
//   slave  : the mirror image, used by the bus model on the other side
interface spi_to_ahb_bridge_if;
    logic [7:0]  HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/spi_to_ahb_bridge.sv
// SPI target (mode 0, MSB first) that turns one chip-select frame from an
// external SPI host into a single AHB-Lite transfer on an 8-bit address space.
// All SPI pins are synchronised into HCLK and oversampled; no sclk-domain logic.
//   Frame: cmd byte {write, size[1:0], 5 ignored}, addr byte, then either
//          32-bit write data, or a dummy byte followed by 32 bits of read data.
// Ports:
//   HCLK, rst       : system clock, synchronous active-high reset
//   sclk, cs_n, mosi: SPI inputs (asynchronous)
//   miso            : SPI output, 0 whenever no read bit is being shifted
//   done            : one-cycle pulse when an AHB data phase completes
//   err             : one-cycle pulse on reserved size, HRESP error or late read
//   ahb             : AHB-Lite master side of the bus
module spi_to_ahb_bridge (
    input  logic HCLK,
    input  logic rst,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic miso,
    output logic done,
    output logic err,
    spi_to_ahb_bridge_if.master ahb
);

    typedef enum logic [3:0] {
        IDLE, CMD, ADDR, WDATA, AHB_A, AHB_D, RWAIT, RDATA, HOLD
    } state_t;

    state_t state_q, state_d;

    // ------------------------------------------------------------------
    // Pin synchronisers and edge detection. The cs chain resets to the
    // "selected" level so that a cs_n held low across reset can never look
    // like a new frame start; a fresh high-then-low is required.
    // ------------------------------------------------------------------
    logic [1:0] sclk_sy, cs_sy, mosi_sy;
    logic       sclk_d, cs_d;

    always_ff @(posedge HCLK) begin
        if (rst) begin
            sclk_sy <= '0;
            cs_sy   <= '0;
            mosi_sy <= '0;
            sclk_d  <= 1'b0;
            cs_d    <= 1'b0;
        end else begin
            sclk_sy <= {sclk_sy[0], sclk};
            cs_sy   <= {cs_sy[0], cs_n};
            mosi_sy <= {mosi_sy[0], mosi};
            sclk_d  <= sclk_sy[1];
            cs_d    <= cs_sy[1];
        end
    end

    logic rise, fall, cs_fall, cs_high;
    assign rise    =  sclk_sy[1] & ~sclk_d;
    assign fall    = ~sclk_sy[1] &  sclk_d;
    assign cs_fall = ~cs_sy[1]   &  cs_d;
    assign cs_high =  cs_sy[1];

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    logic [5:0]  bit_cnt;   // index of the next bit to be sampled
    logic [31:0] rx_q;
    logic [31:0] rx_next;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [7:0]  addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] tx_q;
    logic        late_q;
    logic        done_q, err_q;

    // Includes the bit arriving on this edge, so fields can be latched on
    // the same rise that completes them.
    assign rx_next = {rx_q[30:0], mosi_sy[1]};

    // Control strobes from the FSM
    logic        frame_start, ld_cmd, ld_addr, ld_wdata, cap_rd;
    logic        tx_ld, tx_sh, late_set, done_d, err_d;
    logic [31:0] tx_val;
    logic [31:0] rd_now;
    logic        late_edge;

    assign rd_now    = ahb.HRESP ? 32'h0 : ahb.HRDATA;
    // The falling edge after bit 23 is where bit 24 must appear on miso.
    assign late_edge = fall && (bit_cnt == 6'd24) && !wr_q && !late_q;

    assign ahb.HBURST = 3'b000;
    assign done       = done_q;
    assign err        = err_q;

    always_ff @(posedge HCLK) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        ld_cmd      = 1'b0;
        ld_addr     = 1'b0;
        ld_wdata    = 1'b0;
        cap_rd      = 1'b0;
        tx_ld       = 1'b0;
        tx_sh       = 1'b0;
        tx_val      = '0;
        late_set    = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        ahb.HTRANS  = 2'b00;
        ahb.HADDR   = '0;
        ahb.HWRITE  = 1'b0;
        ahb.HSIZE   = 3'b000;
        ahb.HWDATA  = '0;
        miso        = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    frame_start = 1'b1;
                    state_d     = CMD;
                end
            end
            CMD: begin
                if (cs_high) state_d = IDLE;
                else if (rise && bit_cnt == 6'd7) begin
                    ld_cmd  = 1'b1;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (cs_high) state_d = IDLE;
                else if (rise && bit_cnt == 6'd15) begin
                    ld_addr = 1'b1;
                    if (size_q == 2'b11) begin
                        err_d   = 1'b1;
                        state_d = HOLD;
                    end else if (wr_q) state_d = WDATA;
                    else               state_d = AHB_A;
                end
            end
            WDATA: begin
                if (cs_high) state_d = IDLE;
                else if (rise && bit_cnt == 6'd47) begin
                    ld_wdata = 1'b1;
                    state_d  = AHB_A;
                end
            end
            AHB_A: begin
                // cs_n is deliberately ignored here: the transfer must finish.
                ahb.HTRANS = 2'b10;
                ahb.HADDR  = addr_q;
                ahb.HWRITE = wr_q;
                ahb.HSIZE  = {1'b0, size_q};
                if (late_edge) begin
                    late_set = 1'b1;
                    err_d    = 1'b1;
                    tx_ld    = 1'b1;
                end
                if (ahb.HREADY) state_d = AHB_D;
            end
            AHB_D: begin
                ahb.HWDATA = wr_q ? wdata_q : 32'h0;
                if (ahb.HREADY) begin
                    done_d = 1'b1;
                    err_d  = ahb.HRESP;
                    cap_rd = !wr_q;
                    if (cs_high)     state_d = IDLE;
                    else if (wr_q)   state_d = HOLD;
                    else if (late_q) state_d = RDATA;
                    else if (fall && bit_cnt == 6'd24) begin
                        // completion coincides with the load edge: forward directly
                        tx_ld   = 1'b1;
                        tx_val  = rd_now;
                        state_d = RDATA;
                    end else state_d = RWAIT;
                end else if (late_edge) begin
                    late_set = 1'b1;
                    err_d    = 1'b1;
                    tx_ld    = 1'b1;
                end
            end
            RWAIT: begin
                if (cs_high) state_d = IDLE;
                else if (fall && bit_cnt == 6'd24) begin
                    tx_ld   = 1'b1;
                    tx_val  = rdata_q;
                    state_d = RDATA;
                end
            end
            RDATA: begin
                miso = tx_q[31];
                if (cs_high) state_d = IDLE;
                else if (fall) begin
                    if (bit_cnt >= 6'd56) state_d = HOLD;
                    else                  tx_sh   = 1'b1;
                end
            end
            HOLD: begin
                if (cs_high) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (rst) begin
            bit_cnt <= '0;
            rx_q    <= '0;
            wr_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            tx_q    <= '0;
            late_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= done_d;
            err_q  <= err_d;
            if (frame_start) begin
                bit_cnt <= '0;
                rx_q    <= '0;
                tx_q    <= '0;
                late_q  <= 1'b0;
            end else begin
                if (rise) begin
                    rx_q <= rx_next;
                    // saturate so trailing edges can never alias a bit index
                    if (bit_cnt != 6'h3f) bit_cnt <= bit_cnt + 6'd1;
                end
                if (tx_ld)      tx_q <= tx_val;
                else if (tx_sh) tx_q <= {tx_q[30:0], 1'b0};
                if (late_set)   late_q <= 1'b1;
            end
            if (ld_cmd) begin
                wr_q   <= rx_next[7];
                size_q <= rx_next[6:5];
            end
            if (ld_addr)  addr_q  <= rx_next[7:0];
            if (ld_wdata) wdata_q <= rx_next;
            if (cap_rd)   rdata_q <= rd_now;
        end
    end

endmodule

// File: doc/spi_to_ahb_bridge.md
# spi_to_ahb_bridge

SPI target that turns frames from an external SPI master into single AHB-Lite master transfers. It is the reverse path of `ahb_to_spi_bridge`: an off-chip SPI host can read and write the 8-bit AHB address space. The block runs entirely on HCLK. SPI pins are synchronised and oversampled, so no logic runs in the sclk domain. SPI mode 0, MSB first, one AHB transfer per chip-select frame.

## Interface
- No parameters. Address width is 8, data width is 32, SPI mode is 0.
- HCLK  in  1  system clock; every flop is clocked on its rising edge.
- rst  in  1  synchronous, active-high reset, sampled on the HCLK rising edge.
- sclk  in  1  SPI clock from the external master, asynchronous to HCLK.
- cs_n  in  1  SPI chip select, active low, asynchronous.
- mosi  in  1  SPI data in, asynchronous.
- miso  out  1  SPI data out. Driven 0 whenever no data bit is being shifted.
- HADDR  out  8  AHB address.
- HTRANS  out  2  AHB transfer type. 00 = IDLE, 10 = NONSEQ. No other value is driven.
- HWRITE  out  1  AHB direction.
- HSIZE  out  3  AHB transfer size.
- HBURST  out  3  AHB burst type. Constant 000 (SINGLE).
- HWDATA  out  32  AHB write data.
- HRDATA  in  32  AHB read data.
- HREADY  in  1  AHB ready.
- HRESP  in  1  AHB response. 1 = ERROR.
- done  out  1  one-HCLK pulse when an AHB data phase completes.
- err  out  1  one-HCLK pulse when a frame fails (see Operation).

## Operation
- Input synchronisers: sclk, cs_n and mosi each pass through a 2-flop synchroniser.
  - Edges are detected on the synchronised sclk.
  - A rising edge samples mosi and increments bit_cnt (6 bits).
  - A falling edge shifts miso.
- Frame start: the falling edge of cs_n clears bit_cnt and the shift registers.
- Command byte (bits 0–7):
  - [7] = write.
  - [6:5] = size: 00 byte, 01 half, 10 word, 11 reserved.
  - [4:0] ignored.
- Address byte: bits 8–15.
- Write frame: bits 16–47 carry the data word, MSB first.
- Read frame: bits 16–23 are a dummy byte (miso = 0); bits 24–55 return the data word on miso.
- FSM states: IDLE, CMD, ADDR, WDATA, AHB_A, AHB_D, RWAIT, RDATA, HOLD.
  - IDLE → CMD on the falling edge of cs_n.
  - CMD → ADDR after bit 7.
  - ADDR → WDATA (write) or AHB_A (read) after bit 15.
  - A reserved size (11) sends ADDR → HOLD. No AHB transfer occurs, miso stays 0, and err pulses.
  - WDATA → AHB_A after bit 47.
  - AHB_A: drives HTRANS = 10 with HADDR, HWRITE, and HSIZE = {0, size}. Moves to AHB_D on the first cycle in which HREADY = 1.
  - AHB_D: drives HTRANS = 00 and holds HWDATA. Waits for HREADY = 1, then pulses done.
    - A read captures HRDATA.
    - HRESP = 1 also pulses err, and the read word is replaced with 0.
    - Then: write → HOLD; read → RWAIT.
  - RWAIT: the read word loads into the tx shift register at the sclk falling edge that follows bit 23. Then → RDATA.
  - RDATA: shifts 32 bits out, then → HOLD.
  - HOLD → IDLE when cs_n is high.
- Late read: if the AHB read has not completed by the falling edge after bit 23, the block shifts out 0x00000000 and pulses err once.
- Abort: cs_n rising in CMD, ADDR or WDATA → IDLE with no AHB transfer.
- cs_n rising in AHB_A or AHB_D: the AHB transfer runs to completion (the AHB protocol is never violated), then → IDLE.
- Extra sclk edges in HOLD are ignored; miso stays 0.

## Timing
- Reset values:
  - HTRANS = 00, HADDR = 0x00, HWRITE = 0, HSIZE = 000, HBURST = 000, HWDATA = 0.
  - miso = 0, done = 0, err = 0.
  - The FSM is in IDLE.
- Reset mid-frame: reset takes effect on the next HCLK edge.
  - Outputs return to their reset values in that cycle.
  - The remainder of the current frame is ignored until cs_n goes high and then falls again.
- Clock ratio: HCLK must be at least 8× sclk. Each sclk phase is then at least 4 HCLK cycles.
- Pin-to-detect latency: a pin edge is detected 3 HCLK after it occurs. miso changes 3 HCLK after the sclk falling edge.
- Write path: HTRANS = 10 appears 1 HCLK after the rising edge of bit 47 is detected. With HREADY held at 1, done pulses 2 HCLK later.
- Read budget: the AHB read may use up to 8 sclk periods, less 4 HCLK, including wait states.

## Test plan
- Word write: cmd 0xC0, addr 0x24, data 0xDEADBEEF, HREADY = 1 → exactly one NONSEQ with HADDR = 0x24, HWRITE = 1, HSIZE = 010; next cycle HWDATA = 0xDEADBEEF; done pulses once.
- Word read with 2 wait states: cmd 0x40, addr 0x10, HRDATA = 0x12345678 → HWRITE = 0, HSIZE = 010; miso bits 24–55 = 0x12345678; dummy bits 16–23 = 0.
- Write abort: cs_n high after 20 bits of a write frame → HTRANS stays 00; done = 0; err = 0. The next frame works normally.
- Read error: HRESP = 1 in the data phase → done and err each pulse once; miso returns 0x00000000.
- Reserved size: cmd 0xE0 → no transfer; err pulses after bit 15.
- Reset asserted during WDATA → all outputs return to reset values. No AHB transfer occurs until cs_n goes high, then falls, and a new full frame arrives.
